// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use stall and flush control at the ID->EX boundary.
// Tracks DEPTH in-flight destinations and registers resolved operands into EX.
module fwd_hazard_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [ADDR_W-1:0]       id_rs1,
    input  logic [ADDR_W-1:0]       id_rs2,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [ADDR_W-1:0]       id_rd,
    input  logic                    id_we,
    input  logic                    id_is_load,
    input  logic                    ex_flush,
    input  logic [DATA_W-1:0]       rf_rs1_data,
    input  logic [DATA_W-1:0]       rf_rs2_data,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    id_stall,
    output logic                    ex_valid,
    output logic [DATA_W-1:0]       ex_op1,
    output logic [DATA_W-1:0]       ex_op2,
    output logic [SEL_W-1:0]        ex_sel1,
    output logic [SEL_W-1:0]        ex_sel2,
    output logic [15:0]             stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ld;
    } ent_t;

    ent_t ent_q [DEPTH];
    ent_t ent_d [DEPTH];

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;
    logic [SEL_W-1:0]  ex_sel1_q, ex_sel1_d;
    logic [SEL_W-1:0]  ex_sel2_q, ex_sel2_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [ADDR_W-1:0] src  [2];
    logic              used [2];
    logic [DATA_W-1:0] rfd  [2];
    logic [DATA_W-1:0] op   [2];
    logic [SEL_W-1:0]  sel  [2];
    logic              hz   [2];
    logic              raw_stall;
    logic              advance;

    assign src[0]  = id_rs1;
    assign src[1]  = id_rs2;
    assign used[0] = id_rs1_used;
    assign used[1] = id_rs2_used;
    assign rfd[0]  = rf_rs1_data;
    assign rfd[1]  = rf_rs2_data;

    // Scan oldest to youngest so the lowest matching entry wins.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            op[s]  = (src[s] == '0) ? '0 : rfd[s];
            sel[s] = '0;
            hz[s]  = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_q[k].valid && ent_q[k].we && used[s] &&
                    src[s] != '0 && ent_q[k].rd == src[s]) begin
                    op[s]  = stage_data[k*DATA_W +: DATA_W];
                    sel[s] = SEL_W'(k + 1);
                    hz[s]  = ent_q[k].ld && (k < LOAD_LAT);
                end
            end
        end
    end

    assign raw_stall = hz[0] | hz[1];
    assign id_stall  = id_valid & raw_stall & ~ex_flush;
    assign advance   = ~id_stall & ~ex_flush;

    always_comb begin
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
        ent_d[0]    = '0;
        ex_valid_d  = 1'b0;
        ex_op1_d    = ex_op1_q;
        ex_op2_d    = ex_op2_q;
        ex_sel1_d   = ex_sel1_q;
        ex_sel2_d   = ex_sel2_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            ent_d[0]   = '{valid: id_valid, rd: id_rd, we: id_we, ld: id_is_load};
            ex_valid_d = id_valid;
            ex_op1_d   = op[0];
            ex_op2_d   = op[1];
            ex_sel1_d  = sel[0];
            ex_sel2_d  = sel[1];
        end
        if (id_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            ex_valid_q  <= 1'b0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_sel1_q   <= '0;
            ex_sel2_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            ex_valid_q  <= ex_valid_d;
            ex_op1_q    <= ex_op1_d;
            ex_op2_q    <= ex_op2_d;
            ex_sel1_q   <= ex_sel1_d;
            ex_sel2_q   <= ex_sel2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op1    = ex_op1_q;
    assign ex_op2    = ex_op2_q;
    assign ex_sel1   = ex_sel1_q;
    assign ex_sel2   = ex_sel2_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// against a producer-queue reference model.
module tb_fwd_hazard_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LL    = 1;
    localparam int SW    = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [AW-1:0]     id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              id_we, id_is_load, ex_flush;
    logic [DW-1:0]     rf_rs1_data, rf_rs2_data;
    logic [DEPTH*DW-1:0] stage_data;
    logic              id_stall, ex_valid;
    logic [DW-1:0]     ex_op1, ex_op2;
    logic [SW-1:0]     ex_sel1, ex_sel2;
    logic [15:0]       stall_cnt;

    logic [DW-1:0] sd [DEPTH];
    assign stage_data = {sd[2], sd[1], sd[0]};

    always #5 clock = ~clock;

    fwd_hazard_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LOAD_LAT(LL)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_flush(ex_flush),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .stage_data(stage_data),
        .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_sel1(ex_sel1), .ex_sel2(ex_sel2),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } rec_t;

    // pipe[0] is the youngest in-flight instruction (the one in EX).
    rec_t pipe [$];

    logic        m_stall, m_exv;
    logic [31:0] m_op1, m_op2, p_op1, p_op2;
    logic [1:0]  m_sel1, m_sel2, p_sel1, p_sel2;
    logic [15:0] m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void resolve(input logic [4:0] s, input logic u,
                                    input logic [31:0] rf,
                                    output logic [31:0] o,
                                    output logic [1:0] sl,
                                    output logic st);
        o  = (s == 0) ? 32'd0 : rf;
        sl = 2'd0;
        st = 1'b0;
        if (u && s != 0) begin
            for (int k = 0; k < pipe.size(); k++) begin
                if (pipe[k].valid && pipe[k].we && pipe[k].rd == s) begin
                    o  = sd[k];
                    sl = 2'(k + 1);
                    st = pipe[k].ld && (k < LL);
                    break;
                end
            end
        end
    endfunction

    task automatic model_reset();
        rec_t b;
        b = '{0, 0, 0, 0};
        pipe.delete();
        for (int k = 0; k < DEPTH; k++) pipe.push_back(b);
        m_stall = 0; m_exv = 0;
        m_op1 = 0; m_op2 = 0; m_sel1 = 0; m_sel2 = 0; m_cnt = 0;
    endtask

    task automatic predict();
        logic s1, s2;
        #1;
        resolve(id_rs1, id_rs1_used, rf_rs1_data, p_op1, p_sel1, s1);
        resolve(id_rs2, id_rs2_used, rf_rs2_data, p_op2, p_sel2, s2);
        m_stall = id_valid && (s1 || s2) && !ex_flush;
    endtask

    task automatic tick();
        rec_t r;
        predict();
        if (!m_stall && !ex_flush) begin
            r = '{id_valid, id_rd, id_we, id_is_load};
            m_exv = id_valid;
            m_op1 = p_op1; m_op2 = p_op2;
            m_sel1 = p_sel1; m_sel2 = p_sel2;
        end else begin
            r = '{0, 0, 0, 0};
            m_exv = 0;
        end
        if (m_stall && m_cnt != 16'hFFFF) m_cnt++;
        pipe.push_front(r);
        void'(pipe.pop_back());
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit v, input bit [4:0] rs1, input bit u1,
                         input bit [4:0] rs2, input bit u2,
                         input bit [4:0] rd, input bit we, input bit ld,
                         input bit fl);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_is_load = ld; ex_flush = fl;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1;
        model_reset();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        issue(1, 3, 1, 4, 1, 0, 0, 0, 0);
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got %b exp 0", id_stall);
        end
        n_tests++;
        if (ex_valid !== 1'b0 || ex_op1 !== 0 || ex_op2 !== 0) begin
            n_fail++;
            $display("FAIL reset_ex got v=%b op1=%h op2=%h exp 0", ex_valid, ex_op1, ex_op2);
        end
        n_tests++;
        if (ex_sel1 !== 0 || ex_sel2 !== 0 || stall_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_sel got s1=%0d s2=%0d cnt=%0d exp 0", ex_sel1, ex_sel2, stall_cnt);
        end
    endtask

    task automatic test_alu_fwd();
        apply_reset();
        issue(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        sd[0] = 32'h1234;
        issue(1, 3, 1, 0, 0, 9, 1, 0, 0);
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_fwd_stall got %b exp 0", id_stall);
        end
        tick();
        n_tests++;
        if (ex_op1 !== 32'h1234 || ex_sel1 !== 2'd1 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_fwd got op1=%h sel1=%0d v=%b exp 1234/1/1", ex_op1, ex_sel1, ex_valid);
        end
    endtask

    task automatic test_youngest();
        apply_reset();
        issue(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        tick();
        sd[0] = 32'hAAAA;
        sd[1] = 32'hBBBB;
        rf_rs2_data = 32'h0101;
        issue(1, 0, 0, 5, 1, 6, 1, 0, 0);
        tick();
        n_tests++;
        if (ex_op2 !== 32'hAAAA || ex_sel2 !== 2'd1) begin
            n_fail++;
            $display("FAIL youngest got op2=%h sel2=%0d exp aaaa/1", ex_op2, ex_sel2);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        sd[0] = 32'h1111;
        sd[1] = 32'h5555;
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        issue(1, 7, 1, 0, 0, 8, 1, 0, 0);
        predict();
        n_tests++;
        if (id_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall got %b exp 1", id_stall);
        end
        tick();
        n_tests++;
        if (ex_valid !== 1'b0 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_use_bubble got v=%b cnt=%0d exp 0/1", ex_valid, stall_cnt);
        end
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_release got %b exp 0", id_stall);
        end
        tick();
        n_tests++;
        if (ex_op1 !== 32'h5555 || ex_sel1 !== 2'd2 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_fwd got op1=%h sel1=%0d v=%b exp 5555/2/1", ex_op1, ex_sel1, ex_valid);
        end
    endtask

    task automatic test_reg0();
        apply_reset();
        issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        sd[0] = 32'hDEAD;
        rf_rs1_data = 32'h7777;
        issue(1, 0, 1, 0, 0, 4, 1, 0, 0);
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_stall got %b exp 0", id_stall);
        end
        tick();
        n_tests++;
        if (ex_op1 !== 32'd0 || ex_sel1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reg0 got op1=%h sel1=%0d exp 0/0", ex_op1, ex_sel1);
        end
    endtask

    task automatic test_flush_stall();
        apply_reset();
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        issue(1, 7, 1, 0, 0, 8, 1, 0, 1);
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall got %b exp 0", id_stall);
        end
        tick();
        n_tests++;
        if (ex_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL flush_bubble got v=%b cnt=%0d exp 0/0", ex_valid, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        sd[1] = 32'h5555;
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        issue(1, 7, 1, 0, 0, 8, 1, 0, 0);
        tick();
        tick();
        issue(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        issue(1, 7, 1, 0, 0, 8, 1, 0, 0);
        predict();
        n_tests++;
        if (id_stall !== 1'b1 || stall_cnt !== 16'd1 || ex_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stall_setup got st=%b cnt=%0d v=%b exp 1/1/1", id_stall, stall_cnt, ex_valid);
        end
        reset = 1;
        #1;
        n_tests++;
        if (id_stall !== 0 || ex_valid !== 0 || ex_op1 !== 0 || ex_op2 !== 0 ||
            ex_sel1 !== 0 || ex_sel2 !== 0 || stall_cnt !== 0) begin
            n_fail++;
            $display("FAIL mid_stall_clear got st=%b v=%b op1=%h sel1=%0d cnt=%0d exp all 0",
                     id_stall, ex_valid, ex_op1, ex_sel1, stall_cnt);
        end
        model_reset();
        @(negedge clock);
        reset = 0;
        rf_rs1_data = 32'h4242;
        #1;
        predict();
        n_tests++;
        if (id_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_stall got %b exp 0", id_stall);
        end
        tick();
        n_tests++;
        if (ex_sel1 !== 2'd0 || ex_op1 !== 32'h4242) begin
            n_fail++;
            $display("FAIL post_reset_rf got op1=%h sel1=%0d exp 4242/0", ex_op1, ex_sel1);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(9) < 8,
                  5'($urandom_range(4)), 1'($urandom),
                  5'($urandom_range(4)), 1'($urandom),
                  5'($urandom_range(4)), $urandom_range(9) < 8,
                  $urandom_range(9) < 3, $urandom_range(9) < 1);
            for (int k = 0; k < DEPTH; k++) sd[k] = $urandom;
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
            predict();
            n_tests++;
            if (id_stall !== m_stall) begin
                n_fail++;
                $display("FAIL rand_stall[%0d] got %b exp %b", i, id_stall, m_stall);
            end
            tick();
            n_tests++;
            if (ex_valid !== m_exv || ex_op1 !== m_op1 || ex_op2 !== m_op2 ||
                ex_sel1 !== m_sel1 || ex_sel2 !== m_sel2 || stall_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_ex[%0d] got v=%b %h/%0d %h/%0d cnt=%0d exp v=%b %h/%0d %h/%0d cnt=%0d",
                         i, ex_valid, ex_op1, ex_sel1, ex_op2, ex_sel2, stall_cnt,
                         m_exv, m_op1, m_sel1, m_op2, m_sel2, m_cnt);
            end
        end
    endtask

    initial begin
        reset = 1;
        for (int k = 0; k < DEPTH; k++) sd[k] = 0;
        rf_rs1_data = 0;
        rf_rs2_data = 0;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_alu_fwd();
        test_youngest();
        test_load_use();
        test_reg0();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the pipelined CPU core; replaces the fixed alu_compare/mem_compare/muxh_* pairs.
- Tracks in-flight destination registers in a DEPTH-entry shift register and selects the youngest valid producer for each ID-stage source operand.
- Detects load-use hazards and stalls ID. Handles branch/jump flush.
- Registers the resolved operands into the EX stage.

Parameters:
- DATA_W, 32, operand/result width
- ADDR_W, 5, register address width (2**ADDR_W registers; register 0 hardwired zero)
- DEPTH, 3, tracked in-flight stages after ID (entry 0 = EX, 1 = MEM, 2 = WB, ...)
- LOAD_LAT, 1, lowest entry index at which a load's data is forwardable (1..DEPTH-1)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  ADDR_W  source register addresses
- id_rs1_used, id_rs2_used  input  1  source actually read by the opcode
- id_rd  input  ADDR_W  destination address
- id_we  input  1  instruction writes the register file
- id_is_load  input  1  instruction is a load
- ex_flush  input  1  branch/jump resolved taken in EX this cycle
- rf_rs1_data, rf_rs2_data  input  DATA_W  register file read data (committed state)
- stage_data  input  DEPTH*DATA_W  result of entry k at bits [k*DATA_W +: DATA_W]
- id_stall  output  1  hold PC and ID (combinational)
- ex_valid  output  1  EX holds a real instruction (registered)
- ex_op1, ex_op2  output  DATA_W  resolved operands for EX (registered)
- ex_sel1, ex_sel2  output  $clog2(DEPTH+1)  source used: 0 = RF, k+1 = entry k (registered, debug)
- stall_cnt  output  16  saturating count of stall cycles

Behaviour:
- Reset (asynchronous) clears all entries (valid = 0), ex_valid, ex_op1/2, ex_sel1/2 and stall_cnt to 0. id_stall = 0 while all entries are invalid.
- Entry fields: valid, rd, we, is_load.
- Every clock, entry k moves to k+1. The top entry retires; its write is assumed visible in rf_*_data from the next cycle.
- Match for source s on entry k: entry.valid & entry.we & entry.rd == s & s != 0 & the source's used bit.
- Youngest match (lowest k) wins. No match, or s == 0, selects the RF value (0 for s == 0).
- Data ready for the winning entry if !is_load, or if k >= LOAD_LAT.
- Winning entry not ready gives raw_stall. id_stall = id_valid & raw_stall & !ex_flush.
- Normal advance (no stall, no flush):
  - entry 0 <= {id_valid, id_rd, id_we, id_is_load}
  - ex_valid <= id_valid
  - ex_op1/2 and ex_sel1/2 <= resolved values
- Stall:
  - entry 0 <= bubble (valid = 0); ex_valid <= 0; ex_op/sel hold their previous value.
  - stall_cnt increments and saturates at 16'hFFFF.
- Flush:
  - The ID instruction is discarded: entry 0 <= bubble, ex_valid <= 0, id_stall = 0.
  - Older entries are unaffected, since the branch itself is in EX.
- Flush dominates stall in the same cycle.
- An older stall does not block retirement; entries continue to shift.
- id_valid = 0: bubble inserted, id_stall = 0.
- Reset asserted mid-stall: immediate clear. The first cycle after reset has no stall.
- Both sources may resolve from different entries in the same cycle. A stall on either source stalls the whole instruction.
- Latency: operands are available on ex_op* one clock after ID accepts the instruction.

Test Plan:
- Back-to-back ALU dependency: entry 0 = {rd=3, we}, stage_data[0] = 32'h1234; ID rs1 = 3 → no stall; next cycle ex_op1 = 32'h1234, ex_sel1 = 1.
- Youngest wins: entry 0 rd=5 data 32'hAAAA, entry 1 rd=5 data 32'hBBBB; ID rs2 = 5 → ex_op2 = 32'hAAAA, ex_sel2 = 1.
- Load-use: load rd=7 in entry 0, ID rs1 = 7 → id_stall = 1 for exactly 1 cycle, ex_valid = 0, stall_cnt = 1. Next cycle ex_op1 = stage_data[1], ex_sel1 = 2.
- Register 0: entry 0 rd = 0 with we, ID rs1 = 0 → ex_op1 = 0, ex_sel1 = 0, no stall.
- Flush + stall: load-use condition while ex_flush = 1 → id_stall = 0, ex_valid = 0 next cycle, stall_cnt unchanged.
- Reset mid-stall: assert reset during a load-use stall → all outputs 0 immediately. After release, ID rs1 = 7 reads rf_rs1_data (ex_sel1 = 0).
